// File: rtl/display_scan_controller.sv
// Multiplexes one active-low 7-segment bus across DIGITS common-anode digits.
// A blank gap is inserted between digits, and leading zeros can optionally be suppressed.
module display_scan_controller #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned IDX_W        = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scan_tick,
    input  logic                  enable,
    input  logic                  blank_leading_zeros,
    input  logic [4*DIGITS-1:0]   digit_values,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_select,
    output logic [IDX_W-1:0]      scan_index,
    output logic                  frame_done
);

    localparam int unsigned CNT_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_q, frame_d;
    logic             s1_q, s2_q, s3_q;
    logic             tick_rise;

    logic [3:0]       cur_digit;
    logic [6:0]       seg_dec;
    logic             upper_zero;

    assign tick_rise = s2_q & ~s3_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            frame_q <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            s1_q    <= scan_tick;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (!enable) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StShow;
                    idx_d   = '0;
                end
                StShow: begin
                    // Ticks outside SHOW are dropped, never queued.
                    if (tick_rise) begin
                        state_d = StBlank;
                        cnt_d   = CNT_LOAD;
                    end
                end
                StBlank: begin
                    if (cnt_q == '0) begin
                        state_d = StShow;
                        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        frame_d = (idx_q == IDX_LAST);
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        cur_digit  = digit_values[4*idx_q +: 4];
        // This digit and every more-significant one are zero.
        upper_zero = (digit_values >> (4 * idx_q)) == '0;
        case (cur_digit)
            4'd0:    seg_dec = 7'h40;
            4'd1:    seg_dec = 7'h79;
            4'd2:    seg_dec = 7'h24;
            4'd3:    seg_dec = 7'h30;
            4'd4:    seg_dec = 7'h19;
            4'd5:    seg_dec = 7'h12;
            4'd6:    seg_dec = 7'h02;
            4'd7:    seg_dec = 7'h78;
            4'd8:    seg_dec = 7'h00;
            4'd9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
    end

    always_comb begin
        segments     = 7'h7F;
        digit_select = '1;
        if (state_q == StShow) begin
            digit_select[idx_q] = 1'b0;
            if (!(blank_leading_zeros && (idx_q != '0) && upper_zero)) begin
                segments = seg_dec;
            end
        end
        scan_index = idx_q;
        frame_done = frame_q;
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized scoreboard bench for display_scan_controller.
// An abstract timeline model predicts each cycle's outputs, and a monitor checks them on falling edges.
module tb_display_scan_controller;

    localparam int D = 4;
    localparam int B = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        scan_tick = 1'b0;
    logic        enable = 1'b0;
    logic        blz = 1'b0;
    logic [15:0] dv = 16'h0;
    logic [6:0]  segments;
    logic [3:0]  digit_select;
    logic [1:0]  scan_index;
    logic        frame_done;

    always #5 clock = ~clock;

    display_scan_controller #(
        .DIGITS      (D),
        .BLANK_CYCLES(B),
        .IDX_W       (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .scan_tick          (scan_tick),
        .enable             (enable),
        .blank_leading_zeros(blz),
        .digit_values       (dv),
        .segments           (segments),
        .digit_select       (digit_select),
        .scan_index         (scan_index),
        .frame_done         (frame_done)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] sel;
        logic [1:0] idx;
        logic       frame;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    logic [6:0] seg_tab[16];
    bit         async_pending = 1'b0;
    event       async_chk;

    // Model: dark display, position shown, blank cycles still to go, wrap flag.
    bit m_dark;
    int m_pos;
    int m_blank;
    bit m_frame;
    bit tq[$];

    task automatic model_reset();
        m_dark  = 1'b1;
        m_pos   = 0;
        m_blank = 0;
        m_frame = 1'b0;
        tq.delete();
        repeat (3) tq.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit rise;
        tq.push_back(scan_tick);
        // A level seen at edge m-2 that was low at edge m-3 acts at edge m.
        rise = tq[tq.size()-3] && !tq[tq.size()-4];
        void'(tq.pop_front());
        if (!enable) begin
            m_dark = 1'b1; m_pos = 0; m_blank = 0; m_frame = 1'b0;
        end else if (m_dark) begin
            m_dark = 1'b0; m_pos = 0; m_frame = 1'b0;
        end else if (m_blank > 0) begin
            m_blank--;
            m_frame = 1'b0;
            if (m_blank == 0) begin
                m_pos   = (m_pos + 1) % D;
                m_frame = (m_pos == 0);
            end
        end else begin
            m_frame = 1'b0;
            if (rise) m_blank = B;
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        int   d;
        e.idx   = m_pos[1:0];
        e.frame = m_frame;
        e.seg   = 7'h7F;
        e.sel   = 4'hF;
        if (!m_dark && m_blank == 0) begin
            e.sel[m_pos] = 1'b0;
            d = int'((dv >> (4 * m_pos)) & 16'hF);
            if (!(blz && m_pos > 0 && (dv >> (4 * m_pos)) == 16'h0)) e.seg = seg_tab[d];
        end
        return e;
    endfunction

    task automatic step(input bit en, input bit tk, input bit bz, input logic [15:0] v);
        @(posedge clock);
        model_edge();
        #2;
        enable    = en;
        scan_tick = tk;
        blz       = bz;
        dv        = v;
        exp_q.push_back(predict());
    endtask

    task automatic run(input int n, input bit en, input bit tk, input bit bz,
                       input logic [15:0] v);
        for (int i = 0; i < n; i++) step(en, tk, bz, v);
    endtask

    task automatic tick_frames(input int n, input bit bz, input logic [15:0] v);
        for (int i = 0; i < n; i++) begin
            run(3, 1'b1, 1'b1, bz, v);
            run(17, 1'b1, 1'b0, bz, v);
        end
    endtask

    // Reset asserted between edges; outputs must respond before any clock edge.
    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b1;
        async_pending = 1'b1;
        #1;
        ->async_chk;
        @(posedge clock);
        #2;
        reset = 1'b0;
        async_pending = 1'b0;
        model_reset();
        exp_q.push_back(predict());
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock or async_chk);
            if (async_pending && reset) begin
                total++;
                if (segments !== 7'h7F || digit_select !== 4'hF || scan_index !== 2'd0 ||
                    frame_done !== 1'b0) begin
                    bad++;
                    $display("FAIL async_reset t=%0t: got seg=%h sel=%b idx=%0d frame=%b, want seg=7f sel=1111 idx=0 frame=0",
                             $time, segments, digit_select, scan_index, frame_done);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (segments !== e.seg || digit_select !== e.sel || scan_index !== e.idx ||
                    frame_done !== e.frame) begin
                    bad++;
                    $display("FAIL scan t=%0t: got seg=%h sel=%b idx=%0d frame=%b, want seg=%h sel=%b idx=%0d frame=%b",
                             $time, segments, digit_select, scan_index, frame_done,
                             e.seg, e.sel, e.idx, e.frame);
                end
            end
        end
    end

    initial begin
        bit          tk;
        bit          bz;
        bit          en;
        logic [15:0] v;
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        model_reset();
        do_reset();

        run(30, 1'b1, 1'b0, 1'b0, 16'h1234);
        tick_frames(5, 1'b0, 16'h1234);
        tick_frames(4, 1'b1, 16'h0070);
        tick_frames(4, 1'b0, 16'h0070);

        // Second rise lands inside the blank gap and must be dropped.
        run(1, 1'b1, 1'b1, 1'b0, 16'h00AF);
        run(2, 1'b1, 1'b0, 1'b0, 16'h00AF);
        run(2, 1'b1, 1'b1, 1'b0, 16'h00AF);
        run(20, 1'b1, 1'b0, 1'b0, 16'h00AF);

        // Enable dropped mid-blank, then restored.
        run(1, 1'b1, 1'b1, 1'b0, 16'h1234);
        run(4, 1'b1, 1'b0, 1'b0, 16'h1234);
        run(3, 1'b0, 1'b0, 1'b0, 16'h1234);
        run(10, 1'b1, 1'b0, 1'b0, 16'h1234);

        // Move off digit 0, then pulse reset between edges.
        tick_frames(2, 1'b0, 16'h5678);
        do_reset();
        run(10, 1'b1, 1'b0, 1'b0, 16'h9012);

        tk = 1'b0;
        bz = 1'b1;
        v  = 16'h0305;
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 59) != 0);
            if ($urandom_range(0, 4) == 0) tk = ~tk;
            if ($urandom_range(0, 40) == 0) bz = ~bz;
            if ($urandom_range(0, 25) == 0) begin
                case ($urandom_range(0, 3))
                    0: v = 16'($urandom);
                    1: v = 16'($urandom) & 16'h00FF;
                    2: v = 16'($urandom) & 16'h000F;
                    default: v = 16'h0000;
                endcase
            end
            step(en, tk, bz, v);
        end

        run(3, 1'b1, 1'b0, 1'b0, 16'h1234);
        @(negedge clock);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
